// File: rtl/time2stamp_pkg.sv
// time2stamp shared definitions: epoch and seconds constants, FSM state
// encoding, days-in-month table and shift-add multiply/leap helpers.
package time_pkg;

   localparam int unsigned   EPOCH_YEAR_C  = 1970;
   localparam logic [16:0]   SECS_PER_DAY  = 17'd86400;
   localparam logic [16:0]   SECS_PER_HOUR = 17'd3600;
   localparam logic [16:0]   SECS_PER_MIN  = 17'd60;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      YEARS  = 3'd1,
      MONTHS = 3'd2,
      ACC    = 3'd3,
      DONE   = 3'd4
   } state_e;

   // Element 0 is January; February holds the common-year value.
   localparam logic [0:11][4:0] DIM_TABLE_C = {
      5'd31, 5'd28, 5'd31, 5'd30, 5'd31, 5'd30,
      5'd31, 5'd31, 5'd30, 5'd31, 5'd30, 5'd31
   };

   // Multiply by a small constant using only shifts and adds, one term per set bit.
   function automatic logic [63:0] shift_add_mul(input logic [63:0] x, input logic [16:0] k);
      logic [63:0] acc;
      acc = 64'd0;
      for (int i = 0; i < 17; i++) begin
         if (k[i]) begin
            acc = acc + (x << i);
         end else begin
            acc = acc;
         end
      end
      return acc;
   endfunction

   // Gregorian leap rule evaluated directly on a year value.
   function automatic logic is_leap_year(input logic [13:0] y);
      return ((y % 14'd4) == 14'd0) &&
             (((y % 14'd100) != 14'd0) || ((y % 14'd400) == 14'd0));
   endfunction

endpackage

// File: rtl/time2stamp_if.sv
// time2stamp request/result bundle: calendar fields and start go in,
// busy/done/error/stamp come back.
interface time2stamp_if;
   logic        start;
   logic [13:0] year;
   logic [3:0]  month;
   logic [4:0]  day;
   logic [4:0]  hour;
   logic [5:0]  minute;
   logic [5:0]  second;
   logic        busy;
   logic        done;
   logic        error;
   logic [63:0] stamp;

   modport master (
      output start, year, month, day, hour, minute, second,
      input  busy, done, error, stamp
   );

   modport slave (
      input  start, year, month, day, hour, minute, second,
      output busy, done, error, stamp
   );
endinterface

// File: rtl/time2stamp_days_in_month.sv
// days_in_month: combinational month length lookup, 0 for an invalid month.
module days_in_month
   import time_pkg::*;
(
   input  logic [3:0] month,
   input  logic       leap,
   output logic [4:0] dim
);

   logic [3:0] idx_s;

   // Table lookup with the February leap override.
   always_comb begin
      dim   = 5'd0;
      idx_s = month - 4'd1;
      if ((month >= 4'd1) && (month <= 4'd12)) begin
         if ((month == 4'd2) && leap) begin
            dim = 5'd29;
         end else begin
            dim = DIM_TABLE_C[idx_s];
         end
      end else begin
         dim = 5'd0;
      end
   end

endmodule

// File: rtl/time2stamp.sv
// time2stamp: iterative calendar-to-Unix-seconds converter.
// Walks years from the epoch accumulating 365/366 (leap tracked by
// mod-4/100/400 residues, no divider), then months, then one shift-add
// accumulate cycle. Optional macro TIME2STAMP_VALIDATE_EN adds full
// day/hour/minute/second validation at capture.
module time2stamp
   import time_pkg::*;
#(
   parameter int unsigned EPOCH_YEAR = EPOCH_YEAR_C,
   parameter int unsigned YEAR_MAX   = 9999
)
(
   input  logic          clk,
   input  logic          rst,
   time2stamp_if.slave   bus
);

   localparam logic [13:0] EPOCH_Y_C  = 14'(EPOCH_YEAR);
   localparam logic [13:0] YEAR_MAX_C = 14'(YEAR_MAX);
   localparam logic [1:0]  R4_INIT_C   = 2'(EPOCH_YEAR % 4);
   localparam logic [6:0]  R100_INIT_C = 7'(EPOCH_YEAR % 100);
   localparam logic [8:0]  R400_INIT_C = 9'(EPOCH_YEAR % 400);

   state_e      state_r, state_n_s;

   logic [13:0] year_r;
   logic [3:0]  month_r;
   logic [4:0]  day_r;
   logic [4:0]  hour_r;
   logic [5:0]  minute_r;
   logic [5:0]  second_r;

   logic [13:0] y_r;
   logic [1:0]  r4_r;
   logic [6:0]  r100_r;
   logic [8:0]  r400_r;
   logic [22:0] days_r;
   logic [3:0]  m_r;
   logic        leap_t_r;

   logic        busy_r;
   logic        done_r;
   logic        error_r;
   logic [63:0] stamp_r;

   logic        leap_s;
   logic [4:0]  dim_s;
   logic        field_bad_s;
   logic        reject_s;
   logic [63:0] tot_days_s;
   logic [63:0] stamp_n_s;

   assign bus.busy  = busy_r;
   assign bus.done  = done_r;
   assign bus.error = error_r;
   assign bus.stamp = stamp_r;

   // Leap flag for the year the iterator currently points at.
   assign leap_s = (r4_r == 2'd0) && ((r100_r != 7'd0) || (r400_r == 9'd0));

   days_in_month u_dim_months (
      .month (m_r),
      .leap  (leap_t_r),
      .dim   (dim_s)
   );

`ifdef TIME2STAMP_VALIDATE_EN
   logic       leap_cap_s;
   logic [4:0] dim_cap_s;

   assign leap_cap_s = is_leap_year(year_r);

   days_in_month u_dim_validate (
      .month (month_r),
      .leap  (leap_cap_s),
      .dim   (dim_cap_s)
   );

   assign field_bad_s = (day_r == 5'd0) || (day_r > dim_cap_s) ||
                        (hour_r > 5'd23) || (minute_r > 6'd59) || (second_r > 6'd59);
`else
   assign field_bad_s = 1'b0;
`endif

   // Any rejected capture bypasses the iteration and reports error.
   assign reject_s = (year_r < EPOCH_Y_C) || (year_r > YEAR_MAX_C) ||
                     (month_r == 4'd0) || (month_r > 4'd12) || field_bad_s;

   // Final seconds value; day-1 and the sum wrap naturally in 64 bits.
   always_comb begin
      tot_days_s = 64'(days_r) + 64'(day_r) - 64'd1;
      stamp_n_s  = shift_add_mul(tot_days_s, SECS_PER_DAY) +
                   shift_add_mul(64'(hour_r), SECS_PER_HOUR) +
                   shift_add_mul(64'(minute_r), SECS_PER_MIN) +
                   64'(second_r);
   end

   // FSM state register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_n_s;
      end
   end

   // FSM next-state decode.
   always_comb begin
      state_n_s = state_r;
      case (state_r)
         IDLE: begin
            if (bus.start) begin
               state_n_s = YEARS;
            end else begin
               state_n_s = IDLE;
            end
         end
         YEARS: begin
            if (reject_s) begin
               state_n_s = DONE;
            end else if (y_r == year_r) begin
               state_n_s = MONTHS;
            end else begin
               state_n_s = YEARS;
            end
         end
         MONTHS: begin
            if (m_r == month_r) begin
               state_n_s = ACC;
            end else begin
               state_n_s = MONTHS;
            end
         end
         ACC:     state_n_s = DONE;
         DONE:    state_n_s = IDLE;
         default: state_n_s = IDLE;
      endcase
   end

   // Datapath: capture, year/month accumulation, result and status outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         year_r   <= 14'd0;
         month_r  <= 4'd0;
         day_r    <= 5'd0;
         hour_r   <= 5'd0;
         minute_r <= 6'd0;
         second_r <= 6'd0;
         y_r      <= 14'd0;
         r4_r     <= 2'd0;
         r100_r   <= 7'd0;
         r400_r   <= 9'd0;
         days_r   <= 23'd0;
         m_r      <= 4'd0;
         leap_t_r <= 1'b0;
         busy_r   <= 1'b0;
         done_r   <= 1'b0;
         error_r  <= 1'b0;
         stamp_r  <= 64'd0;
      end else begin
         case (state_r)
            IDLE: begin
               if (bus.start) begin
                  year_r   <= bus.year;
                  month_r  <= bus.month;
                  day_r    <= bus.day;
                  hour_r   <= bus.hour;
                  minute_r <= bus.minute;
                  second_r <= bus.second;
                  y_r      <= EPOCH_Y_C;
                  r4_r     <= R4_INIT_C;
                  r100_r   <= R100_INIT_C;
                  r400_r   <= R400_INIT_C;
                  days_r   <= 23'd0;
                  m_r      <= 4'd1;
                  busy_r   <= 1'b1;
               end
            end
            YEARS: begin
               if (reject_s) begin
                  error_r <= 1'b1;
                  done_r  <= 1'b1;
                  busy_r  <= 1'b0;
               end else if (y_r == year_r) begin
                  leap_t_r <= leap_s;
               end else begin
                  days_r <= days_r + (leap_s ? 23'd366 : 23'd365);
                  y_r    <= y_r + 14'd1;
                  r4_r   <= r4_r + 2'd1;
                  r100_r <= (r100_r == 7'd99)  ? 7'd0 : r100_r + 7'd1;
                  r400_r <= (r400_r == 9'd399) ? 9'd0 : r400_r + 9'd1;
               end
            end
            MONTHS: begin
               if (m_r != month_r) begin
                  days_r <= days_r + {18'd0, dim_s};
                  m_r    <= m_r + 4'd1;
               end
            end
            ACC: begin
               stamp_r <= stamp_n_s;
               error_r <= 1'b0;
               done_r  <= 1'b1;
               busy_r  <= 1'b0;
            end
            DONE: begin
               done_r <= 1'b0;
            end
            default: begin
               done_r <= 1'b0;
               busy_r <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_time2stamp.sv
// Directed bench for time2stamp: vector table plus corner-case sequences.
module tb_time2stamp;

   logic clk = 1'b0;
   logic rst = 1'b1;

   time2stamp_if bus ();

   time2stamp dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [13:0] year;
      logic [3:0]  month;
      logic [4:0]  day;
      logic [4:0]  hour;
      logic [5:0]  minute;
      logic [5:0]  second;
      logic        exp_err;
      logic [63:0] exp_stamp;
      int          exp_lat;
   } vec_t;

   vec_t vecs [15];
   int   checks   = 0;
   int   failures = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
      end
   endtask

   // Present fields with start for one sampled edge, then scramble them.
   task automatic drive_start(input vec_t v);
      @(negedge clk);
      bus.year   = v.year;
      bus.month  = v.month;
      bus.day    = v.day;
      bus.hour   = v.hour;
      bus.minute = v.minute;
      bus.second = v.second;
      bus.start  = 1'b1;
      @(posedge clk);
      #1;
      bus.start  = 1'b0;
      bus.year   = 14'd1969;
      bus.month  = 4'd13;
      bus.day    = 5'd7;
      bus.hour   = 5'd9;
      bus.minute = 6'd33;
      bus.second = 6'd44;
   endtask

   // Count edges until done is seen; -1 if the bound expires.
   task automatic wait_done(input int start_cnt, output int cnt);
      int c;
      c = start_cnt;
      cnt = -1;
      while (c < 20000) begin
         @(posedge clk);
         #1;
         c++;
         if (bus.done === 1'b1) begin
            cnt = c;
            break;
         end
      end
   endtask

   initial begin
      int   lat;
      int   nd;
      vec_t v;

      bus.start = 1'b0;  bus.year = 14'd0;  bus.month = 4'd0;
      bus.day = 5'd0;    bus.hour = 5'd0;   bus.minute = 6'd0;  bus.second = 6'd0;

      vecs[0]  = '{14'd1970, 4'd1,  5'd1,  5'd0,  6'd0,  6'd0,  1'b0, 64'd0,            3};
      vecs[1]  = '{14'd1970, 4'd1,  5'd2,  5'd0,  6'd0,  6'd1,  1'b0, 64'd86401,        3};
      vecs[2]  = '{14'd2024, 4'd8,  5'd30, 5'd16, 6'd14, 6'd50, 1'b0, 64'd1725034490,   64};
      vecs[3]  = '{14'd1969, 4'd1,  5'd1,  5'd0,  6'd0,  6'd0,  1'b1, 64'd1725034490,   1};
      vecs[4]  = '{14'd2000, 4'd3,  5'd1,  5'd0,  6'd0,  6'd0,  1'b0, 64'd951868800,    35};
      vecs[5]  = '{14'd2024, 4'd13, 5'd1,  5'd0,  6'd0,  6'd0,  1'b1, 64'd951868800,    1};
      vecs[6]  = '{14'd2100, 4'd3,  5'd1,  5'd0,  6'd0,  6'd0,  1'b0, 64'd4107542400,   135};
      vecs[7]  = '{14'd1972, 4'd12, 5'd31, 5'd23, 6'd59, 6'd59, 1'b0, 64'd94694399,     16};
      vecs[8]  = '{14'd2024, 4'd0,  5'd1,  5'd0,  6'd0,  6'd0,  1'b1, 64'd94694399,     1};
      vecs[9]  = '{14'd10000,4'd1,  5'd1,  5'd0,  6'd0,  6'd0,  1'b1, 64'd94694399,     1};
      vecs[10] = '{14'd2024, 4'd2,  5'd29, 5'd0,  6'd0,  6'd0,  1'b0, 64'd1709164800,   58};
`ifdef TIME2STAMP_VALIDATE_EN
      vecs[11] = '{14'd2023, 4'd2,  5'd29, 5'd0,  6'd0,  6'd0,  1'b1, 64'd1709164800,   1};
`else
      vecs[11] = '{14'd2023, 4'd2,  5'd29, 5'd0,  6'd0,  6'd0,  1'b0, 64'd1677628800,   57};
`endif
      vecs[12] = '{14'd2038, 4'd1,  5'd19, 5'd3,  6'd14, 6'd7,  1'b0, 64'd2147483647,   71};
      vecs[13] = '{14'd9999, 4'd12, 5'd31, 5'd23, 6'd59, 6'd59, 1'b0, 64'd253402300799, 8043};
`ifdef TIME2STAMP_VALIDATE_EN
      vecs[14] = '{14'd1970, 4'd1,  5'd1,  5'd24, 6'd0,  6'd0,  1'b1, 64'd253402300799, 1};
`else
      vecs[14] = '{14'd1970, 4'd1,  5'd1,  5'd24, 6'd0,  6'd0,  1'b0, 64'd86400,        3};
`endif

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      check("rst_busy",  64'(bus.busy),  64'd0);
      check("rst_done",  64'(bus.done),  64'd0);
      check("rst_error", 64'(bus.error), 64'd0);
      check("rst_stamp", bus.stamp,      64'd0);
      @(negedge clk);
      rst = 1'b0;

      // Table: each row starts in the cycle right after the previous DONE.
      for (int i = 0; i < 15; i++) begin
         drive_start(vecs[i]);
         wait_done(0, lat);
         check($sformatf("v%0d_latency", i), 64'(lat), 64'(vecs[i].exp_lat));
         check($sformatf("v%0d_error", i),   64'(bus.error), 64'(vecs[i].exp_err));
         check($sformatf("v%0d_stamp", i),   bus.stamp, vecs[i].exp_stamp);
         @(posedge clk);
         #1;
         check($sformatf("v%0d_done_pulse", i), 64'(bus.done), 64'd0);
      end

      // Second start at edge 5 during a 2024 conversion is ignored.
      drive_start(vecs[2]);
      check("busy_after_accept", 64'(bus.busy), 64'd1);
      repeat (4) @(posedge clk);
      @(negedge clk);
      bus.year = 14'd1970; bus.month = 4'd1; bus.day = 5'd1;
      bus.start = 1'b1;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      wait_done(5, lat);
      check("restart_latency", 64'(lat), 64'd64);
      check("restart_stamp", bus.stamp, 64'd1725034490);
      nd = 0;
      repeat (100) begin
         @(posedge clk);
         #1;
         if (bus.done === 1'b1) nd++;
      end
      check("restart_single_done", 64'(nd), 64'd0);

      // start during DONE is ignored.
      drive_start(vecs[0]);
      wait_done(0, lat);
      check("done_start_latency", 64'(lat), 64'd3);
      @(negedge clk);
      bus.start = 1'b1;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      check("done_start_busy1", 64'(bus.busy), 64'd0);
      @(posedge clk);
      #1;
      check("done_start_busy2", 64'(bus.busy), 64'd0);

      // Load a nonzero stamp, then reset at edge 10 of a 2024 conversion.
      drive_start(vecs[1]);
      wait_done(0, lat);
      check("pre_rst_stamp", bus.stamp, 64'd86401);
      @(posedge clk);
      drive_start(vecs[2]);
      repeat (10) @(posedge clk);
      #1;
      rst = 1'b1;
      #1;
      check("midrst_busy",  64'(bus.busy),  64'd0);
      check("midrst_done",  64'(bus.done),  64'd0);
      check("midrst_stamp", bus.stamp,      64'd0);
      @(negedge clk);
      rst = 1'b0;
      nd = 0;
      repeat (100) begin
         @(posedge clk);
         #1;
         if (bus.done === 1'b1) nd++;
      end
      check("midrst_no_done", 64'(nd), 64'd0);
      check("midrst_stamp_hold", bus.stamp, 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/time2stamp.md
Name: time2stamp

Overview:
- Converts binary UTC calendar fields (year, month, day, hour, minute, second) into a 64-bit Unix timestamp (seconds since 1970-01-01 00:00:00).
- Inverse of the stamp-to-time path. Used when the user sets the clock: edited fields go in, the result loads the free-running 64-bit seconds counter.
- Iterative and multi-cycle, with a start/busy/done handshake. No divider; leap years come from incrementally tracked residues.

Parameters:
- EPOCH_YEAR, 1970, first year counted; years below it are rejected.
- YEAR_MAX, 9999, highest accepted year; bounds worst-case latency.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle request; sampled only in IDLE.
- year  in  14  calendar year, binary.
- month  in  4  1..12.
- day  in  5  1..31.
- hour  in  5  0..23.
- minute  in  6  0..59.
- second  in  6  0..59.
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  one-cycle pulse when stamp/error are updated.
- error  out  1  input rejected; held until the next done.
- stamp  out  64  result; held until the next done.

Behaviour:
- Reset: busy=0, done=0, error=0, stamp=0, state=IDLE. Reset mid-conversion aborts immediately; stamp keeps no partial value.
- Input capture: on start in IDLE, all fields are registered. Input changes afterwards have no effect.
- start while busy or in DONE: ignored.
- States: IDLE -> YEARS -> MONTHS -> ACC -> DONE -> IDLE.
- YEARS:
  - Iterator y starts at EPOCH_YEAR. Residues start at r4=2, r100=70, r400=370; each wraps at its modulus when y increments.
  - Each cycle with y<year: days += leap(y) ? 366 : 365; then y++.
  - leap = (r4==0) && (r100!=0 || r400==0).
  - Exit when y==year. The residues then describe the target year; latch leap_t.
- MONTHS:
  - Iterator m starts at 1. Each cycle with m<month: days += dim(m, leap_t); m++.
  - dim: 31/28/31/30/31/30/31/31/30/31/30/31, with Feb = 29 when leap_t.
  - Exit when m==month.
- ACC, one cycle: stamp_n = (days + day − 1)·86400 + hour·3600 + minute·60 + second.
  - Constant multiplies are computed as shift-add.
  - days is 23 bits; intermediate width is 64 bits with no truncation.
- DONE: stamp<=stamp_n, error<=0, done=1 for one cycle, busy=0 in the same cycle; next state IDLE.
- Latency: done rises exactly (year−EPOCH_YEAR)+(month−1)+3 clock edges after the edge that samples start. Example: 1970-01 gives 3.
- Rejection (always active): year<EPOCH_YEAR, year>YEAR_MAX, or month==0 or month>12.
  - Skips YEARS/MONTHS/ACC and goes straight to DONE after 1 cycle.
  - error=1, stamp unchanged.
- Out-of-range day/hour/minute/second are not checked without the optional feature; the arithmetic result wraps naturally.

Optional Feature:
- Macro: TIME2STAMP_VALIDATE_EN.
- Defined: full field validation at capture, rejected through the same early-DONE path (error=1, stamp unchanged). Checks:
  - day==0 or day > dim(month, leap(year)); leap(year) is a combinational check on the captured year.
  - hour>23, minute>59 or second>59.
- Undefined: only the year/month rejection applies.

Decomposition:
- Shared package time_pkg holds:
  - EPOCH_YEAR_C=1970, SECS_PER_DAY=86400, SECS_PER_HOUR=3600, SECS_PER_MIN=60.
  - The state encoding enum (IDLE, YEARS, MONTHS, ACC, DONE).
  - The 12-entry days-in-month constant table.
- One natural sub-module: days_in_month, combinational. Inputs month[3:0] and leap; output 5-bit dim. Reused by MONTHS and by the validation logic.

Test Plan:
- 1970-01-01 00:00:00, start -> done at edge 3, stamp=0, error=0.
- 2024-08-30 16:14:50 -> stamp=1725034490, done at edge 54+7+3=64.
- 2000-03-01 00:00:00 (400-year leap) -> 951868800. 2100-03-01 00:00:00 (century non-leap) -> 4107542400.
- year=1969 or month=13 -> done after 1 cycle, error=1, stamp retains the previous value. With TIME2STAMP_VALIDATE_EN: 2023-02-29 -> error=1; 2024-02-29 -> 1709164800.
- Second start pulse at edge 5 during a 2024 conversion -> ignored, single done. Assert rst at edge 10 -> busy=0, done never fires, stamp=0.
- Back-to-back: start in the cycle after done -> accepted, correct second result.
